// File: rtl/sd_seq_gen.sv
// rtl/sd_seq_gen.sv - srdy/drdy incrementing sequence producer with programmable srdy gap pattern
// Optional pseudo-random gaps on top of the pattern: define SDLIB_SEQ_GEN_LFSR_GAP_EN.
module sd_seq_gen #(
  parameter int width     = 8,
  parameter int pat_dep   = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [cnt_width-1:0] count,
  input  logic [width-1:0]     init_value,
  input  logic [pat_dep-1:0]   srdy_pat,
  output logic                 p_srdy,
  input  logic                 p_drdy,
  output logic [width-1:0]     p_data,
  output logic                 busy,
  output logic                 done,
  output logic [cnt_width-1:0] sent_cnt
);

  localparam int ptr_w = (pat_dep > 1) ? $clog2(pat_dep) : 1;
  localparam logic [ptr_w-1:0] ptr_last = ptr_w'(pat_dep - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_n;
  logic [width-1:0]     seq, seq_n, seq_after;
  logic [cnt_width-1:0] remaining, remaining_n, rem_after;
  logic [pat_dep-1:0]   pat, pat_n;
  logic [ptr_w-1:0]     ptr, ptr_n;
  logic                 p_srdy_n, busy_n, done_n;
  logic [width-1:0]     p_data_n;
  logic [cnt_width-1:0] sent_cnt_n;
  logic                 xfer, slot, offer_bit;

`ifdef SDLIB_SEQ_GEN_LFSR_GAP_EN
  logic [15:0] lfsr, lfsr_n;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign offer_bit = pat[ptr] & lfsr[0];

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= lfsr_n;
  end
`else
  assign offer_bit = pat[ptr];
`endif

  assign xfer      = p_srdy & p_drdy;
  // A slot is any RUN cycle that is not a stalled offer; only slots may change the offer.
  assign slot      = (state == RUN) & (~p_srdy | p_drdy);
  assign rem_after = xfer ? remaining - cnt_width'(1) : remaining;
  assign seq_after = xfer ? seq + width'(1) : seq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      seq       <= '0;
      remaining <= '0;
      pat       <= '0;
      ptr       <= '0;
      p_srdy    <= 1'b0;
      p_data    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      state     <= state_n;
      seq       <= seq_n;
      remaining <= remaining_n;
      pat       <= pat_n;
      ptr       <= ptr_n;
      p_srdy    <= p_srdy_n;
      p_data    <= p_data_n;
      busy      <= busy_n;
      done      <= done_n;
      sent_cnt  <= sent_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    seq_n       = seq;
    remaining_n = remaining;
    pat_n       = pat;
    ptr_n       = ptr;
    p_srdy_n    = p_srdy;
    p_data_n    = p_data;
    busy_n      = busy;
    done_n      = 1'b0;
    sent_cnt_n  = sent_cnt;
`ifdef SDLIB_SEQ_GEN_LFSR_GAP_EN
    lfsr_n      = lfsr;
`endif

    case (state)
      IDLE: begin
        p_srdy_n = 1'b0;
        busy_n   = 1'b0;
        if (start) begin
          sent_cnt_n = '0;
          if (count != '0) begin
            state_n     = RUN;
            busy_n      = 1'b1;
            seq_n       = init_value;
            remaining_n = count;
            pat_n       = srdy_pat;
            ptr_n       = '0;
          end else begin
            done_n = 1'b1;
          end
        end
      end

      RUN: begin
        busy_n = 1'b1;
        if (xfer) begin
          seq_n       = seq_after;
          remaining_n = rem_after;
          sent_cnt_n  = sent_cnt + cnt_width'(1);
        end
        if (slot) begin
          if (rem_after == '0) begin
            state_n  = IDLE;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            p_srdy_n = 1'b0;
          end else begin
            p_srdy_n = offer_bit;
            p_data_n = seq_after;
            ptr_n    = (ptr == ptr_last) ? '0 : ptr + ptr_w'(1);
`ifdef SDLIB_SEQ_GEN_LFSR_GAP_EN
            lfsr_n   = {lfsr[14:0], lfsr_fb};
`endif
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_seq_gen.sv
// tb/tb_sd_seq_gen.sv - scoreboard bench for sd_seq_gen with directed and randomized runs
module tb_sd_seq_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] count;
  logic [7:0]  init_value;
  logic [7:0]  srdy_pat;
  logic        p_srdy;
  logic        p_drdy;
  logic [7:0]  p_data;
  logic        busy;
  logic        done;
  logic [15:0] sent_cnt;

  sd_seq_gen dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .init_value(init_value), .srdy_pat(srdy_pat), .p_srdy(p_srdy),
    .p_drdy(p_drdy), .p_data(p_data), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  exp_q[$];
  bit          hist[$];
  logic [15:0] exp_sent = '0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          done_cyc = -1;
  int          first_srdy_cyc = -1;
  int          xfer_cnt = 0;
  int          n_start = 0;
  int          drdy_mode = 0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Consumer ready: 0 always ready, 1 random, 2 stall five offered cycles then ready
  initial begin
    p_drdy = 0;
    forever begin
      @(posedge clk);
      #1;
      case (drdy_mode)
        0: p_drdy = 1;
        1: p_drdy = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_cnt < 5) begin
            p_drdy = 0;
            if (p_srdy) stall_cnt++;
          end else begin
            p_drdy = 1;
          end
        end
        default: p_drdy = 0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks handshake rules
  initial begin
    bit         prev_stall = 0;
    bit         prev_done = 0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      hist.push_back(p_srdy);
      if (reset) begin
        prev_stall = 0;
        prev_done  = 0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_srdy", p_srdy, 1);
          check("stall_hold_data", p_data, prev_data);
        end
        if (p_srdy) begin
          check("srdy_implies_busy", busy, 1);
          if (first_srdy_cyc < 0) first_srdy_cyc = cyc;
        end
        if (p_srdy && p_drdy) begin
          xfer_cnt++;
          if (exp_q.size() == 0) fail_now("unexpected_transfer");
          else check("data", p_data, exp_q.pop_front());
        end
        if (prev_done) check("done_one_cycle", done, 0);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_sent_cnt", sent_cnt, exp_sent);
          check("done_busy_low", busy, 0);
        end
        prev_stall = p_srdy && !p_drdy;
        prev_data  = p_data;
        prev_done  = done;
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1;
    exp_q.delete();
    @(posedge clk); #2;
    reset = 0;
  endtask

  task automatic start_run(input logic [7:0] iv, input int cnt, input logic [7:0] pat, input int mode);
    @(posedge clk); #2;
    drdy_mode      = mode;
    stall_cnt      = 0;
    init_value     = iv;
    count          = 16'(cnt);
    srdy_pat       = pat;
    start          = 1;
    n_start        = cyc;
    exp_sent       = 16'(cnt);
    done_base      = done_cnt;
    first_srdy_cyc = -1;
    xfer_cnt       = 0;
    hist.delete();
    for (int i = 0; i < cnt; i++) begin
      logic [7:0] v;
      v = iv + 8'(i);
      exp_q.push_back(v);
    end
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic wait_done(input int budget, input logic [15:0] cnt);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (done_cnt == done_base) begin
      fail_now("run_timeout");
      pulse_reset();
    end else begin
      repeat (2) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      check("single_done", done_cnt - done_base, 1);
      check("final_sent_cnt", sent_cnt, cnt);
      check("idle_after_run", busy, 0);
    end
  endtask

  // With drdy always high, cycle N+2+k offers exactly when pattern bit k mod 8 is set
  task automatic check_pattern(input logic [7:0] pat, input int cnt);
    bit e[$];
    int k = 0;
    int s = 0;
    e.push_back(0);
    e.push_back(0);
    while (s < cnt) begin
      e.push_back(pat[k % 8]);
      if (pat[k % 8]) s++;
      k++;
    end
    e.push_back(0);
    for (int i = 0; i < e.size(); i++) begin
      if (i < hist.size()) check($sformatf("srdy_pattern[%0d]", i), hist[i], e[i]);
      else fail_now("srdy_history_short");
    end
  endtask

  initial begin
    reset = 1; start = 0; count = '0; init_value = '0; srdy_pat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_p_srdy", p_srdy, 0);
    check("reset_p_data", p_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sent_cnt", sent_cnt, 0);
    @(posedge clk); #2;
    reset = 0;

    // Full-rate run
    start_run(8'h00, 4, 8'hFF, 0);
    @(negedge clk);
    check("busy_at_n1", busy, 1);
    wait_done(100, 16'd4);
    check("t1_first_srdy", first_srdy_cyc, n_start + 2);
    check("t1_done_cycle", done_cyc, n_start + 6);
    check_pattern(8'hFF, 4);

    // Consumer stall on the first item
    start_run(8'h00, 4, 8'hFF, 2);
    wait_done(100, 16'd4);
    check("t2_first_srdy", first_srdy_cyc, n_start + 2);
    check("t2_done_cycle", done_cyc, n_start + 11);

    // Alternating pattern wraps past the last pattern bit
    start_run(8'h00, 6, 8'b01010101, 0);
    wait_done(100, 16'd6);
    check("t3_done_cycle", done_cyc, n_start + 13);
    check_pattern(8'b01010101, 6);

    // Data wraps modulo 256
    start_run(8'hFE, 4, 8'hFF, 0);
    wait_done(100, 16'd4);
    check_pattern(8'hFF, 4);

    // Zero-length run
    start_run(8'h33, 0, 8'hFF, 0);
    wait_done(50, 16'd0);
    check("t5_done_cycle", done_cyc, n_start + 1);
    check("t5_no_srdy", first_srdy_cyc == -1, 1);

    // A start while busy is ignored
    start_run(8'h0A, 6, 8'h55, 0);
    repeat (2) @(posedge clk);
    #2;
    init_value = 8'h99; count = 16'd2; srdy_pat = 8'hFF; start = 1;
    @(posedge clk); #2;
    start = 0;
    wait_done(200, 16'd6);

    // Reset mid-run after two transfers
    start_run(8'h20, 8, 8'hFF, 0);
    begin
      int n = 0;
      while (xfer_cnt < 2 && n < 50) begin
        @(posedge clk); #2;
        n++;
      end
      if (xfer_cnt < 2) fail_now("t6_transfer_timeout");
    end
    reset = 1;
    exp_q.delete();
    @(posedge clk); #2;
    reset = 0;
    @(negedge clk);
    check("t6_srdy_after_reset", p_srdy, 0);
    check("t6_busy_after_reset", busy, 0);
    check("t6_sent_after_reset", sent_cnt, 0);
    repeat (3) @(posedge clk);
    #2;
    check("t6_no_done", done_cnt - done_base, 0);
    start_run(8'h20, 5, 8'hFF, 0);
    wait_done(100, 16'd5);
    check_pattern(8'hFF, 5);

    // Randomized runs with random back-pressure
    for (int r = 0; r < 12; r++) begin
      logic [7:0] iv;
      logic [7:0] pat;
      int         cnt;
      iv  = 8'($urandom_range(0, 255));
      pat = 8'($urandom_range(1, 255));
      cnt = $urandom_range(1, 24);
      start_run(iv, cnt, pat, 1);
      wait_done(3000, 16'(cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_seq_gen.md
Name: sd_seq_gen

Overview:
Srdy/drdy traffic producer for testbenches. It emits a programmable-length, incrementing data sequence on a producer interface, with a configurable srdy gap pattern. It sits directly upstream of the block under test and produces the sequence that the downstream sequence checker consumes. Its purpose is to exercise flow control on both sides of a block under test.

Parameters:
width, 8, data width; the sequence wraps modulo 2^width.
pat_dep, 8, depth of the srdy gap pattern in bits.
cnt_width, 16, width of the transfer count and the sent counter.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse; begins a run when idle
count  input  cnt_width  number of items to send; sampled on accepted start
init_value  input  width  first data value; sampled on accepted start
srdy_pat  input  pat_dep  srdy gap pattern (1 = offer data); sampled on accepted start
p_srdy  output  1  producer data valid
p_drdy  input  1  consumer ready
p_data  output  width  producer data
busy  output  1  run in progress
done  output  1  one-cycle pulse when a run completes
sent_cnt  output  cnt_width  transfers completed in the current or last run

Behaviour:
- All outputs are registered. Reset sets p_srdy=0, p_data=0, busy=0, done=0, sent_cnt=0, state=IDLE, ptr=0, and clears internal seq/remaining/pattern registers.
- Reset asserted mid-run aborts the run immediately. No done pulse is generated.
- Transfer condition: p_srdy & p_drdy in the same cycle.
- States:
  - IDLE: p_srdy=0, busy=0.
  - RUN: busy=1.
- IDLE, start with count!=0 (cycle N):
  - Latch seq=init_value, remaining=count, pat=srdy_pat; set ptr=0 and sent_cnt=0.
  - Go to RUN; busy=1 from cycle N+1.
- IDLE, start with count==0: stay in IDLE, sent_cnt=0, done=1 in cycle N+1. p_srdy never asserts.
- start in RUN is ignored.
- "Offer slot" in RUN: any cycle where p_srdy==0, or a transfer occurs.
  - In an offer slot, ptr advances: ptr=(ptr+1) mod pat_dep.
  - Next p_srdy = pat[ptr] & (remaining after this cycle != 0).
  - Next p_data = current seq value.
  - Earliest first p_srdy is cycle N+2.
- While p_srdy & !p_drdy: p_srdy, p_data and ptr hold stable. No retraction is allowed.
- On transfer:
  - seq = seq+1 mod 2^width.
  - remaining -= 1; sent_cnt += 1.
  - If pat[ptr] is set and items remain, p_srdy stays high and p_data advances next cycle. This gives full throughput with no bubble.
- On the last transfer (remaining becomes 0): next cycle p_srdy=0, busy=0, state=IDLE, done=1 for exactly one cycle. sent_cnt holds its final value until the next accepted start or reset.
- All-zero pattern: p_srdy never asserts and the run never completes. This is legal; the bench must avoid or time out on it.
- sent_cnt saturates at count; no wrap within a run.

Optional Feature:
SDLIB_SEQ_GEN_LFSR_GAP_EN:
- Defined:
  - A 16-bit Fibonacci LFSR is added (taps 16,14,13,11), seeded 16'hACE1 on reset.
  - The LFSR advances in every offer slot.
  - The offer decision becomes pat[ptr] & lfsr[0], giving pseudo-random gaps on top of the pattern.
  - Handshake rules are unchanged.
- Not defined: no LFSR logic exists, and the offer decision is pat[ptr] only.

Test Plan:
1. reset, then srdy_pat=8'hFF, init_value=0, count=4, p_drdy=1, start at cycle N -> p_data 0,1,2,3 with p_srdy high in cycles N+2..N+5; done pulses at N+6; sent_cnt=4; busy low at N+6.
2. Same run, with p_drdy=0 for 5 cycles after the first p_srdy -> p_srdy stays 1 and p_data stays 0 throughout the stall; the sequence then resumes at 1 with no skip or duplicate.
3. srdy_pat=8'b01010101, count=6, p_drdy=1 -> p_srdy alternates 1,0,1,0...; p_data values are 0..5 in order; the pattern wraps past ptr=7 correctly.
4. init_value=8'hFE, count=4 -> p_data FE, FF, 00, 01; done pulses once.
5. start with count=0 -> done pulses the next cycle, p_srdy stays 0. Also: a second start while busy leaves remaining and sent_cnt unaffected.
6. reset asserted mid-run after 2 transfers -> next cycle p_srdy=0, busy=0, sent_cnt=0, no done pulse; a new start then begins again from init_value.
